// File: rtl/camino_datos_booth.sv
// Registered datapath for a radix-2 Booth signed multiplier.
// Holds A (with guard bit), Q, Q-1 and M, and captures the product once per Fin rise.
module camino_datos_booth #(
   parameter int unsigned N = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   multiplicando,
   input  logic [N-1:0]   multiplicador,
   input  logic           CargaQ,
   input  logic           CargaM,
   input  logic           CargaA,
   input  logic           Resta,
   input  logic           DesplazaAQ,
   input  logic           Fin,
   output logic [N-1:0]   q,
   output logic           qsub1,
   output logic [2*N-1:0] producto,
   output logic           producto_valido
);

   // A carries one guard bit so that M = -2^(N-1) cannot overflow the accumulator.
   logic [N:0]     a_q, a_d;
   logic [N-1:0]   q_q, q_d;
   logic           qsub1_q, qsub1_d;
   logic [N:0]     m_q, m_d;
   logic           fin_prev_q;
   logic [2*N-1:0] prod_q, prod_d;
   logic           valid_d;

   // Next state of the working registers; CargaQ wins, then add/sub, then shift.
   always_comb begin
      a_d     = a_q;
      q_d     = q_q;
      qsub1_d = qsub1_q;
      m_d     = m_q;
      if (CargaM) begin
         m_d = {multiplicando[N-1], multiplicando};
      end
      if (CargaQ) begin
         q_d     = multiplicador;
         a_d     = '0;
         qsub1_d = 1'b0;
      end else if (CargaA) begin
         // A simultaneous DesplazaAQ is dropped here on purpose.
         a_d = Resta ? (a_q - m_q) : (a_q + m_q);
      end else if (DesplazaAQ) begin
         {a_d, q_d, qsub1_d} = {a_q[N], a_q, q_q};
      end
   end

   // Product capture on the rising edge of the Fin level.
   always_comb begin
      valid_d = Fin & ~fin_prev_q;
      prod_d  = valid_d ? {a_q[N-1:0], q_q} : prod_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q             <= '0;
         q_q             <= '0;
         qsub1_q         <= 1'b0;
         m_q             <= '0;
         fin_prev_q      <= 1'b0;
         prod_q          <= '0;
         producto_valido <= 1'b0;
      end else begin
         a_q             <= a_d;
         q_q             <= q_d;
         qsub1_q         <= qsub1_d;
         m_q             <= m_d;
         fin_prev_q      <= Fin;
         prod_q          <= prod_d;
         producto_valido <= valid_d;
      end
   end

   assign q        = q_q;
   assign qsub1    = qsub1_q;
   assign producto = prod_q;

endmodule

// File: tb/tb_camino_datos_booth.sv
// Self-checking bench for camino_datos_booth: drives Booth strobe sequences
// and compares against plain signed multiplication.
module tb_camino_datos_booth;

   localparam int unsigned N = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   multiplicando, multiplicador;
   logic           CargaQ, CargaM, CargaA, Resta, DesplazaAQ, Fin;
   logic [N-1:0]   q;
   logic           qsub1;
   logic [2*N-1:0] producto;
   logic           producto_valido;

   int n_cmp = 0;
   int n_err = 0;

   camino_datos_booth #(.N(N)) dut (
      .clk             (clk),
      .reset           (reset),
      .multiplicando   (multiplicando),
      .multiplicador   (multiplicador),
      .CargaQ          (CargaQ),
      .CargaM          (CargaM),
      .CargaA          (CargaA),
      .Resta           (Resta),
      .DesplazaAQ      (DesplazaAQ),
      .Fin             (Fin),
      .q               (q),
      .qsub1           (qsub1),
      .producto        (producto),
      .producto_valido (producto_valido)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      CargaQ = 0; CargaM = 0; CargaA = 0; Resta = 0; DesplazaAQ = 0; Fin = 0;
   endtask

   function automatic logic [2*N-1:0] ref_prod(input int a, input int b);
      int p;
      p = a * b;
      return p[2*N-1:0];
   endfunction

   // Full Booth sequence; the control pair is derived from the multiplier bits.
   task automatic run_mult(input int a, input int b, input bit mid_reset);
      logic [N-1:0] bb;
      logic         prev;
      logic [2*N-1:0] exp;
      bb  = b[N-1:0];
      exp = ref_prod(a, b);
      clear_strobes();
      multiplicando = a[N-1:0];
      multiplicador = bb;
      CargaQ = 1; CargaM = 1;
      tick();
      clear_strobes();
      check_eq("load_q", 32'(q), 32'(bb));
      check_eq("load_qsub1", 32'(qsub1), 0);
      for (int i = 0; i < N; i++) begin
         prev = (i == 0) ? 1'b0 : bb[i-1];
         if ({bb[i], prev} == 2'b10) begin
            CargaA = 1; Resta = 1;
         end else if ({bb[i], prev} == 2'b01) begin
            CargaA = 1; Resta = 0;
         end
         tick();
         clear_strobes();
         DesplazaAQ = 1;
         if (mid_reset && i == 1) reset = 1;
         tick();
         clear_strobes();
         if (reset) begin
            check_eq("midrst_q", 32'(q), 0);
            check_eq("midrst_qsub1", 32'(qsub1), 0);
            check_eq("midrst_prod", 32'(producto), 0);
            check_eq("midrst_valid", 32'(producto_valido), 0);
            reset = 0;
            return;
         end
         check_eq("shift_qsub1", 32'(qsub1), 32'(bb[i]));
         if (i < N - 1) check_eq("shift_q0", 32'(q[0]), 32'(bb[i+1]));
      end
      Fin = 1;
      tick();
      check_eq("valid_pulse", 32'(producto_valido), 1);
      check_eq("product", 32'(producto), 32'(exp));
      Fin = 0;
      tick();
      check_eq("valid_drop", 32'(producto_valido), 0);
      check_eq("product_hold", 32'(producto), 32'(exp));
   endtask

   initial begin
      logic [2*N-1:0] held;
      int pulses;
      int a, b;
      clear_strobes();
      multiplicando = '0;
      multiplicador = '0;
      reset = 1;
      for (int i = 0; i < 2; i++) begin
         {CargaQ, CargaM, CargaA, Resta, DesplazaAQ, Fin} = 6'($urandom);
         multiplicando = N'($urandom);
         multiplicador = N'($urandom);
         tick();
      end
      check_eq("rst_q", 32'(q), 0);
      check_eq("rst_qsub1", 32'(qsub1), 0);
      check_eq("rst_prod", 32'(producto), 0);
      check_eq("rst_valid", 32'(producto_valido), 0);
      reset = 0;
      clear_strobes();
      tick();

      // Directed products, including the most-negative corner.
      run_mult(3, -2, 0);
      run_mult(-4, -4, 0);
      run_mult(-4, 3, 0);
      run_mult(0, -3, 0);

      // Fin held high: one pulse only; then a re-arm gives a second pulse.
      held = ref_prod(0, -3);
      pulses = 0;
      Fin = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (producto_valido) pulses++;
      end
      check_eq("fin_held_pulses", 32'(pulses), 1);
      Fin = 0;
      tick();
      Fin = 1;
      tick();
      check_eq("fin_rearm_valid", 32'(producto_valido), 1);
      check_eq("fin_rearm_prod", 32'(producto), 32'(held));
      Fin = 0;
      tick();

      // Reset during the second shift, then a full sequence.
      run_mult(2, 3, 1);
      run_mult(2, 3, 0);

      // CargaA with DesplazaAQ: A <= 0 + M, Q and Q-1 untouched.
      multiplicando = 3'b101;
      multiplicador = 3'b011;
      CargaQ = 1; CargaM = 1;
      tick();
      clear_strobes();
      CargaA = 1; DesplazaAQ = 1; Resta = 0;
      tick();
      clear_strobes();
      check_eq("both_q", 32'(q), 32'(3'b011));
      check_eq("both_qsub1", 32'(qsub1), 0);
      Fin = 1;
      tick();
      check_eq("both_prod", 32'(producto), 32'({3'b101, 3'b011}));
      Fin = 0;
      tick();

      // Randomized operands.
      for (int k = 0; k < 40; k++) begin
         a = int'($urandom_range(7)) - 4;
         b = int'($urandom_range(7)) - 4;
         run_mult(a, b, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
